// File: rtl/asrv32_mem_arbiter_pkg.sv
// asrv32_mem_arbiter_pkg
// Shared types for the instruction/data memory arbiter: FSM state encoding
// and the grant identifiers used to track round-robin fairness.
`timescale 1ns/1ps
package asrv32_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_WAIT = 2'd1,
    DATA_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

endpackage

// File: rtl/asrv32_mem_arbiter.sv
// asrv32_mem_arbiter
// Shares one single-port synchronous memory between the core's instruction
// fetch port and its data load/store port. One access is in flight at a time;
// the memory access is issued combinationally in IDLE and the registered read
// data is returned with a one-cycle ack in the following WAIT state.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_stb_inst, i_inst_addr      instruction request (read-only)
//   o_ack_inst, o_inst           instruction ack pulse and fetched word
//   i_stb_data, i_data_addr,
//   i_data_wr_en, i_data_wr_mask,
//   i_data_wdata                 data load/store request
//   o_ack_data, o_data           data ack pulse and loaded word
//   o_mem_en, o_mem_addr,
//   o_mem_wr_en, o_mem_wr_mask,
//   o_mem_wdata, i_mem_rdata     memory port (read data one cycle after en)
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | no access in flight; arbitrate and issue
// INST_WAIT | instruction access issued; ack it this cycle
// DATA_WAIT | data access issued; ack it this cycle
`timescale 1ns/1ps
module asrv32_mem_arbiter
  import asrv32_mem_arbiter_pkg::*;
#(
  parameter int MEMORY_DEPTH   = 1024,
  parameter int FIXED_PRIORITY = 0,
  localparam int ADDR_W        = $clog2(MEMORY_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stb_inst,
  input  logic [ADDR_W-1:0] i_inst_addr,
  output logic              o_ack_inst,
  output logic [31:0]       o_inst,
  input  logic              i_stb_data,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic              i_data_wr_en,
  input  logic [3:0]        i_data_wr_mask,
  input  logic [31:0]       i_data_wdata,
  output logic              o_ack_data,
  output logic [31:0]       o_data,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wr_en,
  output logic [3:0]        o_mem_wr_mask,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  arb_state_t state_q, state_d;
  grant_t     last_grant_q, last_grant_d;
  logic       pick_data;

  // Byte-offset bits are intentionally dropped: every access is a word access.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_inst_addr[1:0], i_data_addr[1:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_INST;  // first tie after reset goes to data
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Data wins a tie under fixed priority, or under round-robin when the
  // instruction port was served last.
  assign pick_data = i_stb_data &&
                     (!i_stb_inst || (FIXED_PRIORITY != 0) || (last_grant_q == GRANT_INST));

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    o_ack_inst    = 1'b0;
    o_inst        = '0;
    o_ack_data    = 1'b0;
    o_data        = '0;
    o_mem_en      = 1'b0;
    o_mem_addr    = '0;
    o_mem_wr_en   = 1'b0;
    o_mem_wr_mask = '0;
    o_mem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_data) begin
          state_d       = DATA_WAIT;
          last_grant_d  = GRANT_DATA;
          o_mem_en      = 1'b1;
          o_mem_addr    = {i_data_addr[ADDR_W-1:2], 2'b00};
          o_mem_wr_en   = i_data_wr_en;
          o_mem_wr_mask = i_data_wr_en ? i_data_wr_mask : 4'b0000;
          o_mem_wdata   = i_data_wdata;
        end else if (i_stb_inst) begin
          state_d       = INST_WAIT;
          last_grant_d  = GRANT_INST;
          o_mem_en      = 1'b1;
          o_mem_addr    = {i_inst_addr[ADDR_W-1:2], 2'b00};
        end
      end
      INST_WAIT: begin
        o_ack_inst = 1'b1;
        o_inst     = i_mem_rdata;
        state_d    = IDLE;
      end
      DATA_WAIT: begin
        o_ack_data = 1'b1;
        o_data     = i_mem_rdata;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // While reset is held nothing may reach either side: an in-flight ack is
    // dropped and no new access is issued.
    if (i_rst) begin
      o_ack_inst    = 1'b0;
      o_inst        = '0;
      o_ack_data    = 1'b0;
      o_data        = '0;
      o_mem_en      = 1'b0;
      o_mem_addr    = '0;
      o_mem_wr_en   = 1'b0;
      o_mem_wr_mask = '0;
      o_mem_wdata   = '0;
    end
  end

endmodule

// File: tb/tb_asrv32_mem_arbiter.sv
`timescale 1ns/1ps
module tb_asrv32_mem_arbiter;

  localparam int ADDR_W = 10;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_stb_inst;
  logic [ADDR_W-1:0] i_inst_addr;
  logic              o_ack_inst;
  logic [31:0]       o_inst;
  logic              i_stb_data;
  logic [ADDR_W-1:0] i_data_addr;
  logic              i_data_wr_en;
  logic [3:0]        i_data_wr_mask;
  logic [31:0]       i_data_wdata;
  logic              o_ack_data;
  logic [31:0]       o_data;
  logic              o_mem_en;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_wr_en;
  logic [3:0]        o_mem_wr_mask;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  // second instance: fixed priority, memory read data tied off
  logic              rst1;
  logic              stb_i1, stb_d1;
  logic              ack_i1, ack_d1;
  logic [31:0]       unused_inst1, unused_data1, unused_wdata1;
  logic              mem_en1, wr_en1;
  logic [ADDR_W-1:0] mem_addr1;
  logic [3:0]        unused_mask1;
  logic [31:0]       rdata1;

  logic        mem_load;
  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_pass   = 0;
  int acks_i, acks_d;

  always #5 i_clk = ~i_clk;

  asrv32_mem_arbiter #(.MEMORY_DEPTH(1024), .FIXED_PRIORITY(0)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_stb_inst(i_stb_inst), .i_inst_addr(i_inst_addr),
    .o_ack_inst(o_ack_inst), .o_inst(o_inst),
    .i_stb_data(i_stb_data), .i_data_addr(i_data_addr),
    .i_data_wr_en(i_data_wr_en), .i_data_wr_mask(i_data_wr_mask),
    .i_data_wdata(i_data_wdata),
    .o_ack_data(o_ack_data), .o_data(o_data),
    .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr),
    .o_mem_wr_en(o_mem_wr_en), .o_mem_wr_mask(o_mem_wr_mask),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  asrv32_mem_arbiter #(.MEMORY_DEPTH(1024), .FIXED_PRIORITY(1)) dut_fp (
    .i_clk(i_clk), .i_rst(rst1),
    .i_stb_inst(stb_i1), .i_inst_addr(10'h008),
    .o_ack_inst(ack_i1), .o_inst(unused_inst1),
    .i_stb_data(stb_d1), .i_data_addr(10'h040),
    .i_data_wr_en(1'b0), .i_data_wr_mask(4'b0000),
    .i_data_wdata(32'h0),
    .o_ack_data(ack_d1), .o_data(unused_data1),
    .o_mem_en(mem_en1), .o_mem_addr(mem_addr1),
    .o_mem_wr_en(wr_en1), .o_mem_wr_mask(unused_mask1),
    .o_mem_wdata(unused_wdata1), .i_mem_rdata(rdata1)
  );

  assign rdata1 = 32'h0;

  // registered-read memory with byte-enable writes
  always @(posedge i_clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[3] <= 32'h00500093;
      mem[4] <= 32'h44332211;
      mem[5] <= 32'h55555555;
      mem[8] <= 32'h11223344;
      i_mem_rdata <= 32'h0;
    end else if (o_mem_en) begin
      if (o_mem_wr_en)
        for (int b = 0; b < 4; b++)
          if (o_mem_wr_mask[b]) mem[o_mem_addr[9:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      i_mem_rdata <= mem[o_mem_addr[9:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic data_req(input logic stb, input logic [9:0] addr, input logic wr,
                          input logic [3:0] mask, input logic [31:0] wdata);
    i_stb_data     = stb;
    i_data_addr    = addr;
    i_data_wr_en   = wr;
    i_data_wr_mask = mask;
    i_data_wdata   = wdata;
  endtask

  initial begin
    mem_load = 1'b1;
    i_rst = 1'b1;
    rst1 = 1'b1; stb_i1 = 1'b0; stb_d1 = 1'b0;
    i_stb_inst = 1'b1; i_inst_addr = 10'h00C;
    data_req(1'b1, 10'h020, 1'b0, 4'b0000, 32'h0);

    // reset held 3 cycles with both strobes high
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk); #1;
      check("rst_mem_en", o_mem_en, 0);
      check("rst_acks", {o_ack_inst, o_ack_data}, 0);
      check("rst_rdata", o_inst | o_data, 0);
      check("rst_mem_bus", {o_mem_addr, o_mem_wr_en, o_mem_wr_mask}, 0);
    end

    // first grant after reset goes to data
    @(negedge i_clk); i_rst = 1'b0; mem_load = 1'b0; #1;
    check("first_grant_en", o_mem_en, 1);
    check("first_grant_addr", o_mem_addr, 10'h020);
    check("first_grant_we", o_mem_wr_en, 0);
    @(negedge i_clk); #1;
    check("first_ack_data", {o_ack_inst, o_ack_data}, 2'b01);
    check("first_load_data", o_data, 32'h11223344);
    check("first_no_issue", o_mem_en, 0);

    // losing instruction request is served next; single fetch of word 3
    @(negedge i_clk); i_stb_data = 1'b0; #1;
    check("fetch_en", o_mem_en, 1);
    check("fetch_addr", o_mem_addr, 10'h00C);
    check("fetch_ro", {o_mem_wr_en, o_mem_wr_mask}, 0);
    @(negedge i_clk); #1;
    check("fetch_ack", {o_ack_inst, o_ack_data}, 2'b10);
    check("fetch_word", o_inst, 32'h00500093);
    @(negedge i_clk); i_stb_inst = 1'b0; #1;
    check("fetch_idle", {o_mem_en, o_ack_inst, o_ack_data}, 0);
    check("fetch_inst_zero", o_inst, 0);

    // misaligned byte store to 0x13 lands in byte 3 of word 4
    @(negedge i_clk); data_req(1'b1, 10'h013, 1'b1, 4'b1000, 32'hAB000000); #1;
    check("st_addr", o_mem_addr, 10'h010);
    check("st_we_mask", {o_mem_en, o_mem_wr_en, o_mem_wr_mask}, 6'b111000);
    check("st_wdata", o_mem_wdata, 32'hAB000000);
    @(negedge i_clk); #1;
    check("st_ack", {o_ack_inst, o_ack_data}, 2'b01);
    @(negedge i_clk); data_req(1'b1, 10'h010, 1'b0, 4'b1111, 32'hFFFFFFFF); #1;
    check("ld_we_forced", {o_mem_en, o_mem_wr_en, o_mem_wr_mask}, 6'b100000);
    @(negedge i_clk); #1;
    check("ld_after_st", o_data, 32'hAB332211);

    // store with empty mask is issued and acked but writes nothing
    @(negedge i_clk); data_req(1'b1, 10'h014, 1'b1, 4'b0000, 32'hFFFFFFFF); #1;
    check("st0_issue", {o_mem_en, o_mem_wr_en, o_mem_wr_mask}, 6'b110000);
    @(negedge i_clk); #1;
    check("st0_ack", o_ack_data, 1);
    @(negedge i_clk); data_req(1'b1, 10'h014, 1'b0, 4'b0000, 32'h0); #1;
    @(negedge i_clk); #1;
    check("st0_unchanged", o_data, 32'h55555555);

    // round-robin contention from a fresh reset: D, I, D, I
    @(negedge i_clk); i_rst = 1'b1; i_stb_data = 1'b0;
    acks_i = 0; acks_d = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      if (c == 0) begin
        i_rst = 1'b0;
        i_stb_inst = 1'b1; i_inst_addr = 10'h000;
        data_req(1'b1, 10'h020, 1'b0, 4'b0000, 32'h0);
      end
      #1;
      acks_i += int'(o_ack_inst);
      acks_d += int'(o_ack_data);
      if (c % 2 == 0) begin
        check("rr_grant_en", {o_mem_en, o_ack_inst, o_ack_data}, 3'b100);
        check("rr_grant_addr", o_mem_addr, (c % 4 == 0) ? 10'h020 : 10'h000);
      end else begin
        check("rr_ack", {o_mem_en, o_ack_inst, o_ack_data},
              (c % 4 == 1) ? 3'b001 : 3'b010);
      end
    end
    check("rr_ack_inst_count", acks_i, 2);
    check("rr_ack_data_count", acks_d, 2);

    // reset during the wait cycle of a load suppresses the ack; load reissues
    @(negedge i_clk); i_stb_inst = 1'b0; i_stb_data = 1'b0;
    @(negedge i_clk); data_req(1'b1, 10'h020, 1'b0, 4'b0000, 32'h0); #1;
    check("mid_issue", o_mem_en, 1);
    @(negedge i_clk); i_rst = 1'b1; #1;
    check("mid_ack_suppressed", {o_ack_data, o_ack_inst}, 0);
    check("mid_data_zero", o_data, 0);
    @(negedge i_clk); i_rst = 1'b0; #1;
    check("mid_reissue", {o_mem_en, o_mem_addr}, {1'b1, 10'h020});
    @(negedge i_clk); #1;
    check("mid_ack", o_ack_data, 1);
    check("mid_data", o_data, 32'h11223344);
    @(negedge i_clk); i_stb_data = 1'b0;

    // fixed priority: data starves instruction until data drops
    @(negedge i_clk); rst1 = 1'b0; stb_i1 = 1'b1; stb_d1 = 1'b1;
    acks_i = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge i_clk);
      #1;
      acks_i += int'(ack_i1);
      if (c % 2 == 0)
        check("fp_grant_data", {mem_en1, mem_addr1, wr_en1}, {1'b1, 10'h040, 1'b0});
      else
        check("fp_ack_data", {ack_d1, ack_i1}, 2'b10);
    end
    check("fp_inst_starved", acks_i, 0);
    @(negedge i_clk); stb_d1 = 1'b0; #1;
    check("fp_grant_inst", {mem_en1, mem_addr1, ack_i1}, {1'b1, 10'h008, 1'b0});
    @(negedge i_clk); #1;
    check("fp_ack_inst", {ack_i1, ack_d1}, 2'b10);
    @(negedge i_clk); stb_i1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
